// File: rtl/divmmc_spi.sv
// DivMMC SD-card SPI master: decodes the CS/data I/O ports and runs
// one MSB-first mode-0 byte transfer per data-port access.
module divmmc_spi #(
  parameter logic [7:0] PORT_CS   = 8'hE7,
  parameter logic [7:0] PORT_DATA = 8'hEB,
  parameter int         SCK_HALF  = 1
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       ce_i,
  input  logic       iorq_i,
  input  logic       rd_i,
  input  logic       wr_i,
  input  logic [7:0] a_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o,
  output logic       q_oe_o,
  output logic       busy_o,
  output logic [1:0] cs_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    q_q, q_d;
  logic [1:0]    cs_q, cs_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          wacc_q, wacc_d;
  logic          racc_q, racc_d;

  logic       wacc, racc;
  logic       data_w, data_r, cs_w;
  logic       half_done;
  logic [7:0] tx;

  assign wacc = !iorq_i && !wr_i;
  assign racc = !iorq_i && !rd_i;

  // Edge on the sampled access so a long I/O cycle acts only once.
  assign data_w = wacc && !wacc_q && (a_i == PORT_DATA);
  assign data_r = racc && !racc_q && (a_i == PORT_DATA);
  assign cs_w   = wacc && !wacc_q && (a_i == PORT_CS);

  assign half_done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    q_d     = q_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    wacc_d  = wacc_q;
    racc_d  = racc_q;
    tx      = 8'hFF;
    if (ce_i) begin
      wacc_d = wacc;
      racc_d = racc;
      if (cs_w) cs_d = d_i[1:0];
      unique case (state_q)
        IDLE: begin
          if (data_w || data_r) begin
            tx      = data_w ? d_i : 8'hFF;
            shift_d = tx;
            bit_d   = 3'd0;
            cnt_d   = '0;
            mosi_d  = tx[7];
            state_d = LOW;
          end
        end
        LOW: begin
          if (half_done) begin
            cnt_d   = '0;
            sck_d   = 1'b1;
            rx_d    = {rx_q[6:0], miso_i};
            state_d = HIGH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (half_done) begin
            cnt_d = '0;
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              q_d     = rx_q;
              mosi_d  = 1'b1;
              state_d = IDLE;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
              state_d = LOW;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rx_q    <= 8'h00;
      q_q     <= 8'hFF;
      cs_q    <= 2'b11;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      wacc_q  <= 1'b0;
      racc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      q_q     <= q_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      wacc_q  <= wacc_d;
      racc_q  <= racc_d;
    end
  end

  assign q_o    = q_q;
  assign q_oe_o = racc && (a_i == PORT_DATA);
  assign busy_o = (state_q != IDLE);
  assign cs_o   = cs_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: tb/tb_divmmc_spi.sv
// Scoreboard bench for divmmc_spi: stimulus pushes expected bytes and
// MOSI bits, a monitor checks them at SCK rises and busy falls.
module tb_divmmc_spi;

  localparam int SH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce = 1'b1;
  logic       iorq, rd, wr;
  logic [7:0] a, d;
  logic [7:0] q;
  logic       q_oe, busy, sck, mosi, miso;
  logic [1:0] cs;

  divmmc_spi #(
    .PORT_CS  (8'hE7),
    .PORT_DATA(8'hEB),
    .SCK_HALF (SH)
  ) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .ce_i    (ce),
    .iorq_i  (iorq),
    .rd_i    (rd),
    .wr_i    (wr),
    .a_i     (a),
    .d_i     (d),
    .q_o     (q),
    .q_oe_o  (q_oe),
    .busy_o  (busy),
    .cs_o    (cs),
    .sck_o   (sck),
    .mosi_o  (mosi),
    .miso_i  (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    int         ce_len;
    int         raw_len;
  } xfer_t;

  xfer_t xq[$];
  logic  mq[$];
  int    total = 0;
  int    bad = 0;
  int    n_done = 0;
  int    n_exp = 0;
  int    ce_div = 1;
  int    ph = 0;
  int    rise_cnt = 0;
  int    ce_len = 0;
  int    raw_len = 0;
  logic  sck_p = 1'b0;
  logic  busy_p = 1'b0;
  logic [7:0] miso_byte = 8'hFF;
  logic [2:0] mi;

  always_comb begin
    mi   = 3'(7 - rise_cnt);
    miso = miso_byte[mi];
  end

  // ce is updated mid-cycle so the DUT and the monitor see a stable value.
  always @(posedge clk) begin
    #2;
    ph = (ph + 1 >= ce_div) ? 0 : ph + 1;
    ce = (ph == 0);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sck_p    = 1'b0;
      busy_p   = 1'b0;
      ce_len   = 0;
      raw_len  = 0;
      rise_cnt = 0;
    end else begin
      if (busy === 1'b1) begin
        raw_len++;
        if (ce) ce_len++;
      end
      if (sck === 1'b1 && !sck_p) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mosi_extra act=%0b exp=none", mosi);
        end else begin
          check("mosi_bit", 32'(mosi), 32'(mq.pop_front()));
        end
        rise_cnt++;
      end
      if (busy_p && busy === 1'b0) begin
        n_done++;
        if (xq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_extra act=%0h exp=none", q);
        end else begin
          xfer_t e;
          e = xq.pop_front();
          check("q_done", 32'(q), 32'(e.q));
          check("busy_ce", ce_len, e.ce_len);
          check("busy_raw", raw_len, e.raw_len);
        end
        ce_len   = 0;
        raw_len  = 0;
        rise_cnt = 0;
      end
      sck_p  = sck;
      busy_p = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [7:0] ad, input logic [7:0] dd,
                       input int hold);
    a    = ad;
    d    = dd;
    iorq = 1'b0;
    wr   = 1'b0;
    cyc(hold * ce_div);
    iorq = 1'b1;
    wr   = 1'b1;
    cyc(ce_div);
  endtask

  task automatic expect_xfer(input logic [7:0] tx, input logic [7:0] rx);
    xfer_t e;
    for (int i = 7; i >= 0; i--) mq.push_back(tx[i]);
    e.q       = rx;
    e.ce_len  = 16 * SH;
    e.raw_len = 16 * SH * ce_div;
    xq.push_back(e);
    n_exp++;
    miso_byte = rx;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      cyc(1);
      t++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    iorq  = 1'b1;
    rd    = 1'b1;
    wr    = 1'b1;
    a     = 8'h00;
    d     = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    check("rst_cs", 32'(cs), 32'h3);
    check("rst_sck", 32'(sck), 32'h0);
    check("rst_mosi", 32'(mosi), 32'h1);
    check("rst_q", 32'(q), 32'hFF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_qoe", 32'(q_oe), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // CS write then a data-port transfer
    io_wr(8'hE7, 8'hFE, 1);
    check("cs_write", 32'(cs), 32'h2);
    expect_xfer(8'hA5, 8'h3C);
    io_wr(8'hEB, 8'hA5, 1);
    check("busy_start", 32'(busy), 32'h1);
    wait_idle();
    check("q_a5", 32'(q), 32'h3C);

    // pipelined read: returns old q, shifts out all ones
    expect_xfer(8'hFF, 8'h81);
    a    = 8'hEB;
    iorq = 1'b0;
    rd   = 1'b0;
    #1;
    check("rd_qoe", 32'(q_oe), 32'h1);
    check("rd_q_prev", 32'(q), 32'h3C);
    cyc(1);
    iorq = 1'b1;
    rd   = 1'b1;
    cyc(1);
    wait_idle();
    check("q_read", 32'(q), 32'h81);

    // CS-port read and foreign addresses are ignored
    a    = 8'hE7;
    iorq = 1'b0;
    rd   = 1'b0;
    #1;
    check("cs_rd_qoe", 32'(q_oe), 32'h0);
    cyc(1);
    iorq = 1'b1;
    rd   = 1'b1;
    cyc(2);
    check("cs_rd_busy", 32'(busy), 32'h0);
    io_wr(8'h1F, 8'h00, 1);
    check("other_busy", 32'(busy), 32'h0);
    check("other_cs", 32'(cs), 32'h2);

    // writes while busy: data dropped, CS still taken
    expect_xfer(8'hC3, 8'h5A);
    io_wr(8'hEB, 8'hC3, 1);
    cyc(6);
    io_wr(8'hEB, 8'h11, 1);
    io_wr(8'hE7, 8'hFD, 1);
    check("cs_busy_wr", 32'(cs), 32'h1);
    check("busy_mid", 32'(busy), 32'h1);
    wait_idle();
    cyc(4);
    check("drop_busy", 32'(busy), 32'h0);
    check("drop_count", n_done, n_exp);

    // long write cycle: exactly one transfer
    expect_xfer(8'h96, 8'hE1);
    a    = 8'hEB;
    d    = 8'h96;
    iorq = 1'b0;
    wr   = 1'b0;
    cyc(20);
    check("long_busy", 32'(busy), 32'h1);
    iorq = 1'b1;
    wr   = 1'b1;
    wait_idle();
    cyc(40);
    check("long_idle", 32'(busy), 32'h0);
    check("long_count", n_done, n_exp);
    check("long_q", 32'(q), 32'hE1);

    // ce at 1-in-3: same byte, stretched waveform
    ce_div = 3;
    cyc(6);
    expect_xfer(8'hA5, 8'h3C);
    io_wr(8'hEB, 8'hA5, 1);
    wait_idle();
    check("q_slow", 32'(q), 32'h3C);
    ce_div = 1;
    cyc(4);

    // reset in the middle of bit 3
    miso_byte = 8'h42;
    for (int i = 7; i >= 4; i--) mq.push_back(1'((8'hA5 >> i) & 8'h1));
    a    = 8'hEB;
    d    = 8'hA5;
    iorq = 1'b0;
    wr   = 1'b0;
    cyc(1);
    iorq = 1'b1;
    wr   = 1'b1;
    begin
      int t;
      t = 0;
      while (rise_cnt < 4 && t < 200) begin
        cyc(1);
        t++;
      end
      check("bit3_reached", rise_cnt, 4);
    end
    check("pre_rst_sck", 32'(sck), 32'h1);
    check("pre_rst_bits", mq.size(), 0);
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs), 32'h3);
    check("abort_sck", 32'(sck), 32'h0);
    check("abort_mosi", 32'(mosi), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_q", 32'(q), 32'hFF);
    mq.delete();
    xq.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    check("abort_count", n_done, n_exp);
    check("abort_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
